serial_receiver: RTL and testbench

SERIAL_RECEIVER -- requirements
Module: serial_receiver

---
 rtl/serial_receiver.sv | 102 ++++++++++
 tb/tb_serial_receiver.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_receiver.sv
// MSB-first serial-to-parallel receiver with word counter and two hex seven-segment
// glyphs of the count; a dropped valid mid-word aborts the word with a frameErr pulse.
module serial_receiver #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              serIn,
    input  logic              serInValid,
    output logic [DATA_W-1:0] parOut,
    output logic              parOutValid,
    output logic              frameErr,
    output logic [7:0]        byteCount,
    output logic [6:0]        seg0,
    output logic [6:0]        seg1
);

    localparam int SW = DATA_W - 1;
    localparam int CW = $clog2(DATA_W);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state;
    logic [CW-1:0] bitCnt;
    // Only DATA_W-1 bits are ever held; the final bit goes straight into parOut.
    logic [SW-1:0] sh;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            bitCnt      <= '0;
            sh          <= '0;
            parOut      <= '0;
            parOutValid <= 1'b0;
            frameErr    <= 1'b0;
            byteCount   <= '0;
        end else begin
            parOutValid <= 1'b0;
            frameErr    <= 1'b0;
            case (state)
                IDLE: begin
                    if (serInValid) begin
                        sh     <= SW'(serIn);
                        bitCnt <= CW'(1);
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (serInValid) begin
                        if (bitCnt == CW'(DATA_W - 1)) begin
                            parOut      <= {sh, serIn};
                            parOutValid <= 1'b1;
                            byteCount   <= byteCount + 8'd1;
                            bitCnt      <= '0;
                            sh          <= '0;
                            state       <= IDLE;
                        end else begin
                            sh     <= SW'({sh, serIn});
                            bitCnt <= bitCnt + CW'(1);
                        end
                    end else begin
                        frameErr <= 1'b1;
                        bitCnt   <= '0;
                        sh       <= '0;
                        state    <= IDLE;
                    end
                end
            endcase
        end
    end

    function automatic logic [6:0] hex7(input logic [3:0] d);
        logic [6:0] g;
        g = 7'b1111111;
        case (d)
            4'h0: g = 7'b1000000;
            4'h1: g = 7'b1111001;
            4'h2: g = 7'b0100100;
            4'h3: g = 7'b0110000;
            4'h4: g = 7'b0011001;
            4'h5: g = 7'b0010010;
            4'h6: g = 7'b0000010;
            4'h7: g = 7'b1111000;
            4'h8: g = 7'b0000000;
            4'h9: g = 7'b0010000;
            4'hA: g = 7'b0001000;
            4'hB: g = 7'b0000011;
            4'hC: g = 7'b1000110;
            4'hD: g = 7'b0100001;
            4'hE: g = 7'b0000110;
            4'hF: g = 7'b0001110;
            default: g = 7'b1111111;
        endcase
        return g;
    endfunction

    always_comb begin
        seg0 = hex7(byteCount[3:0]);
        seg1 = hex7(byteCount[7:4]);
    end

endmodule

// File: tb/tb_serial_receiver.sv
// Randomised and directed bench for serial_receiver against a bit-counting word model.
module tb_serial_receiver;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       serIn = 1'b0;
    logic       serInValid = 1'b0;
    logic [7:0] parOut;
    logic       parOutValid;
    logic       frameErr;
    logic [7:0] byteCount;
    logic [6:0] seg0;
    logic [6:0] seg1;

    int errors = 0;
    int checks = 0;

    // model state: bits gathered so far for the current word, and expected outputs
    int         m_n = 0;
    int         m_acc = 0;
    logic [7:0] e_par = '0;
    logic       e_pv = 1'b0;
    logic       e_fe = 1'b0;
    int         e_cnt = 0;

    logic [6:0] glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    serial_receiver #(.DATA_W(8)) dut (
        .clk(clk), .rst(rst), .serIn(serIn), .serInValid(serInValid),
        .parOut(parOut), .parOutValid(parOutValid), .frameErr(frameErr),
        .byteCount(byteCount), .seg0(seg0), .seg1(seg1)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance the model across the edge, sample 1ns later.
    task automatic step(input logic v, input logic b, input logic r);
        serInValid = v;
        serIn      = b;
        rst        = r;
        @(posedge clk);
        e_pv = 1'b0;
        e_fe = 1'b0;
        if (r) begin
            m_n = 0; m_acc = 0; e_par = '0; e_cnt = 0;
        end else if (v) begin
            m_acc = m_acc * 2 + int'(b);
            m_n++;
            if (m_n == 8) begin
                e_par = 8'(m_acc);
                e_pv  = 1'b1;
                e_cnt = (e_cnt + 1) % 256;
                m_n = 0; m_acc = 0;
            end
        end else if (m_n > 0) begin
            e_fe = 1'b1;
            m_n = 0; m_acc = 0;
        end
        #1;
    endtask

    task automatic send_word(input logic [7:0] w);
        logic [7:0] t;
        t = w;
        for (int i = 7; i >= 0; i--) step(1'b1, t[i], 1'b0);
    endtask

    task automatic test_reset;
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        checks++; if (parOut !== 8'h00) begin errors++; $display("FAIL reset_parOut got %h exp 00", parOut); end
        checks++; if (parOutValid !== 1'b0) begin errors++; $display("FAIL reset_pv got %b exp 0", parOutValid); end
        checks++; if (frameErr !== 1'b0) begin errors++; $display("FAIL reset_fe got %b exp 0", frameErr); end
        checks++; if (byteCount !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", byteCount); end
        checks++; if (seg0 !== 7'b1000000 || seg1 !== 7'b1000000) begin
            errors++; $display("FAIL reset_seg got %b %b exp 1000000 1000000", seg1, seg0);
        end
    endtask

    task automatic test_single_word;
        int pulses;
        logic [7:0] pat;
        pulses = 0;
        pat = 8'b10101010;
        for (int i = 7; i >= 0; i--) begin
            step(1'b1, pat[i], 1'b0);
            if (parOutValid) pulses++;
            checks++; if (parOutValid !== (i == 0)) begin
                errors++; $display("FAIL aa_pv_bit%0d got %b exp %b", i, parOutValid, (i == 0));
            end
        end
        checks++; if (parOut !== 8'hAA) begin errors++; $display("FAIL aa_parOut got %h exp aa", parOut); end
        checks++; if (byteCount !== 8'd1) begin errors++; $display("FAIL aa_cnt got %0d exp 1", byteCount); end
        checks++; if (seg0 !== 7'b1111001 || seg1 !== 7'b1000000) begin
            errors++; $display("FAIL aa_seg got %b %b exp 1000000 1111001", seg1, seg0);
        end
        step(1'b0, 1'b0, 1'b0);
        if (parOutValid) pulses++;
        checks++; if (pulses != 1) begin errors++; $display("FAIL aa_pulses got %0d exp 1", pulses); end
        checks++; if (parOut !== 8'hAA) begin errors++; $display("FAIL aa_hold got %h exp aa", parOut); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] stream;
        int pulse_at [$];
        logic [7:0] got [$];
        stream = 16'h5AC3;
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, stream[15 - i], 1'b0);
            if (parOutValid) begin pulse_at.push_back(i); got.push_back(parOut); end
        end
        checks++; if (pulse_at.size() != 2) begin
            errors++; $display("FAIL b2b_pulses got %0d exp 2", pulse_at.size());
        end else begin
            checks++; if (pulse_at[1] - pulse_at[0] != 8) begin
                errors++; $display("FAIL b2b_gap got %0d exp 8", pulse_at[1] - pulse_at[0]);
            end
            checks++; if (got[0] !== 8'h5A || got[1] !== 8'hC3) begin
                errors++; $display("FAIL b2b_words got %h %h exp 5a c3", got[0], got[1]);
            end
        end
        checks++; if (byteCount !== 8'd2) begin errors++; $display("FAIL b2b_cnt got %0d exp 2", byteCount); end
    endtask

    task automatic test_frame_error;
        int fe_pulses;
        logic [7:0] w;
        fe_pulses = 0;
        step(1'b0, 1'b0, 1'b1);
        send_word(8'hAA);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'($urandom), 1'b0);
            if (frameErr) fe_pulses++;
        end
        step(1'b0, 1'b0, 1'b0);
        checks++; if (frameErr !== 1'b1 || parOutValid !== 1'b0) begin
            errors++; $display("FAIL ferr_pulse got fe=%b pv=%b exp fe=1 pv=0", frameErr, parOutValid);
        end
        if (frameErr) fe_pulses++;
        step(1'b0, 1'b1, 1'b0);
        if (frameErr) fe_pulses++;
        checks++; if (fe_pulses != 1) begin errors++; $display("FAIL ferr_count got %0d exp 1", fe_pulses); end
        checks++; if (parOut !== 8'hAA || byteCount !== 8'd1) begin
            errors++; $display("FAIL ferr_hold got par=%h cnt=%0d exp par=aa cnt=1", parOut, byteCount);
        end
        w = 8'($urandom);
        send_word(w);
        checks++; if (parOutValid !== 1'b1 || parOut !== w || byteCount !== 8'd2) begin
            errors++; $display("FAIL ferr_next got pv=%b par=%h cnt=%0d exp pv=1 par=%h cnt=2",
                               parOutValid, parOut, byteCount, w);
        end
    endtask

    task automatic test_rst_midword;
        int flags;
        logic [7:0] w;
        flags = 0;
        for (int i = 0; i < 4; i++) step(1'b1, 1'($urandom), 1'b0);
        step(1'b1, 1'b1, 1'b1);
        if (parOutValid || frameErr) flags++;
        step(1'b0, 1'b0, 1'b0);
        if (parOutValid || frameErr) flags++;
        checks++; if (flags != 0) begin errors++; $display("FAIL rstmid_flags got %0d exp 0", flags); end
        checks++; if (parOut !== 8'h00 || byteCount !== 8'd0 || seg0 !== 7'b1000000) begin
            errors++; $display("FAIL rstmid_vals got par=%h cnt=%0d seg0=%b exp 00 0 1000000", parOut, byteCount, seg0);
        end
        w = 8'($urandom);
        send_word(w);
        checks++; if (parOutValid !== 1'b1 || parOut !== w || byteCount !== 8'd1) begin
            errors++; $display("FAIL rstmid_next got pv=%b par=%h cnt=%0d exp pv=1 par=%h cnt=1",
                               parOutValid, parOut, byteCount, w);
        end
    endtask

    task automatic test_idle_toggle;
        int bad;
        bad = 0;
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'(i & 1), 1'b0);
            if (parOut !== e_par || byteCount !== 8'(e_cnt) || parOutValid !== 1'b0 || frameErr !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL idle_toggle got %0d changed cycles exp 0", bad); end
    endtask

    task automatic test_random;
        int bad;
        logic v, b, r;
        bad = 0;
        for (int i = 0; i < 600; i++) begin
            v = ($urandom_range(0, 9) != 0);
            b = 1'($urandom);
            r = ($urandom_range(0, 149) == 0);
            step(v, b, r);
            checks++;
            if (parOut !== e_par || parOutValid !== e_pv || frameErr !== e_fe ||
                byteCount !== 8'(e_cnt) || seg0 !== glyph[e_cnt % 16] || seg1 !== glyph[e_cnt / 16] ||
                (parOutValid && frameErr)) begin
                errors++; bad++;
                if (bad <= 5)
                    $display("FAIL random_cyc%0d got par=%h pv=%b fe=%b cnt=%0d seg=%b/%b exp par=%h pv=%b fe=%b cnt=%0d",
                             i, parOut, parOutValid, frameErr, byteCount, seg1, seg0, e_par, e_pv, e_fe, e_cnt);
            end
        end
    endtask

    task automatic test_wrap;
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 255; i++) send_word(8'($urandom));
        checks++; if (byteCount !== 8'd255 || seg0 !== 7'b0001110 || seg1 !== 7'b0001110) begin
            errors++; $display("FAIL wrap_255 got cnt=%0d seg=%b/%b exp 255 0001110/0001110", byteCount, seg1, seg0);
        end
        send_word(8'h3C);
        checks++; if (byteCount !== 8'd0 || seg0 !== 7'b1000000 || seg1 !== 7'b1000000 || parOut !== 8'h3C) begin
            errors++; $display("FAIL wrap_0 got cnt=%0d seg=%b/%b par=%h exp 0 1000000/1000000 3c",
                               byteCount, seg1, seg0, parOut);
        end
    endtask

    initial begin
        test_reset;
        test_single_word;
        test_back_to_back;
        test_frame_error;
        test_rst_midword;
        test_idle_toggle;
        test_random;
        test_wrap;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
